// File: rtl/uart_rx_framed_if.sv
// Output stream of the framed UART receiver: one received word per beat,
// with its error flags alongside and a valid/ready handshake.
interface uart_rx_framed_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] stream_tdata;
  logic [2:0]           stream_tuser;
  logic                 stream_tvalid;
  logic                 stream_tready;

  // The receiver drives the word; the consumer answers with ready.
  modport master (
    output stream_tdata,
    output stream_tuser,
    output stream_tvalid,
    input  stream_tready
  );

  modport slave (
    input  stream_tdata,
    input  stream_tuser,
    input  stream_tvalid,
    output stream_tready
  );

endinterface

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: start / data / optional parity / stop bits, each bit
// decided by a three-sample majority vote around the bit centre. Received
// words go out on a one-deep valid/ready register; reception never waits
// for the consumer, so a word that finds the register still occupied is
// dropped and the held word is flagged as overrun.
// tuser = {overrun, parity_err, framing_err}.
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxd,
  uart_rx_framed_if.master    stream
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Sample points around the bit centre, counted from the start of each bit.
  localparam logic [CW-1:0] HALF_M1  = CW'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] HALF_P1  = CW'((CLKS_PER_BIT - 1) / 2 + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  // Odd parity wants the XOR of data and parity bit to be 1, even wants 0.
  localparam logic PAR_WANT = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 rxMeta_q;
  logic                 rxs_q;

  logic [2:0]           state_q,  state_d;
  logic [CW-1:0]        clkCnt_q, clkCnt_d;
  logic [3:0]           bitCnt_q, bitCnt_d;
  logic [1:0]           samp_q,   samp_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 parErr_q, parErr_d;
  logic                 frmErr_q, frmErr_d;
  logic                 armed_q,  armed_d;

  logic                 vote;
  logic                 atVote;
  logic                 atLast;
  logic                 complete;
  logic                 completeFrm;

  logic [DATA_BITS-1:0] tdata_q;
  logic [2:0]           tuser_q;
  logic                 tvalid_q;

  // Two-flop synchroniser for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta_q <= 1'b1;
      rxs_q    <= 1'b1;
    end else begin
      rxMeta_q <= rxd;
      rxs_q    <= rxMeta_q;
    end
  end

  assign atVote = (clkCnt_q == HALF_P1);
  assign atLast = (clkCnt_q == BIT_LAST);

  // The third sample is the live synchronised line at the H+1 count.
  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);

  // Frame sequencing: bit timing, sampling, shifting and error collection.
  // armed_q is only set by seeing a high line in IDLE, so a line held low
  // after a frame (break) cannot be mistaken for a fresh start bit.
  always_comb begin
    state_d     = state_q;
    clkCnt_d    = clkCnt_q;
    bitCnt_d    = bitCnt_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    parErr_d    = parErr_q;
    frmErr_d    = frmErr_q;
    armed_d     = armed_q;
    complete    = 1'b0;
    completeFrm = frmErr_q | ~vote;

    if (state_q != S_IDLE) begin
      clkCnt_d = atLast ? '0 : clkCnt_q + 1'b1;
      if (clkCnt_q == HALF_M1) begin
        samp_d[0] = rxs_q;
      end
      if (clkCnt_q == HALF) begin
        samp_d[1] = rxs_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        clkCnt_d = '0;
        bitCnt_d = '0;
        if (rxs_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d  = S_START;
          armed_d  = 1'b0;
          parErr_d = 1'b0;
          frmErr_d = 1'b0;
        end
      end

      S_START: begin
        if (atVote && vote) begin
          state_d = S_IDLE;
        end else if (atLast) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (atVote) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
        end
        if (atLast) begin
          if (bitCnt_q == LAST_DATA) begin
            bitCnt_d = '0;
            state_d  = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (atVote) begin
          parErr_d = ((^shift_q) ^ vote) != PAR_WANT;
        end
        if (atLast) begin
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (atVote) begin
          if (!vote) begin
            frmErr_d = 1'b1;
          end
          if (bitCnt_q == LAST_STOP) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (atLast) begin
          bitCnt_d = bitCnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Receiver state registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      clkCnt_q <= '0;
      bitCnt_q <= '0;
      samp_q   <= '0;
      shift_q  <= '0;
      parErr_q <= 1'b0;
      frmErr_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clkCnt_q <= clkCnt_d;
      bitCnt_q <= bitCnt_d;
      samp_q   <= samp_d;
      shift_q  <= shift_d;
      parErr_q <= parErr_d;
      frmErr_q <= frmErr_d;
      armed_q  <= armed_d;
    end
  end

  // One-deep output register: load when free or being drained this cycle,
  // otherwise drop the new word and mark the held one as overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tdata_q  <= '0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
    end else if (complete) begin
      if (!tvalid_q || stream.stream_tready) begin
        tdata_q  <= shift_q;
        tuser_q  <= {1'b0, parErr_q, completeFrm};
        tvalid_q <= 1'b1;
      end else begin
        tuser_q[2] <= 1'b1;
      end
    end else if (tvalid_q && stream.stream_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign stream.stream_tdata  = tdata_q;
  assign stream.stream_tuser  = tuser_q;
  assign stream.stream_tvalid = tvalid_q;

endmodule
